// File: rtl/frame_capture.sv
// frame_capture: arms on key_flag, waits for the next vsync, then writes one active
// frame (pixel, linear address) toward a frame buffer while checking line/frame geometry.
`default_nettype none

module frame_capture #(
    parameter int H_VALID = 1280,
    parameter int V_VALID = 720,
    parameter int DW      = 16,
    parameter int AW      = 20
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    input  logic          key_flag,
    input  logic          vs_in,
    input  logic          de_in,
    input  logic [DW-1:0] pix_in,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err
);

    localparam int             CW     = 11;
    localparam logic [CW-1:0]  X_MAX  = '1;
    localparam logic [CW-1:0]  H_LIM  = CW'(H_VALID);
    localparam logic [CW-1:0]  Y_LAST = CW'(V_VALID - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q;
    logic            vs_d_q;
    logic            de_d_q;
    logic [CW-1:0]   x_q;
    logic [CW-1:0]   y_q;
    logic            wr_en_q;
    logic [DW-1:0]   wr_data_q;
    logic [AW-1:0]   wr_addr_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic vs_rise;
    logic de_fall;
    logic last_line_end;

    assign vs_rise       = vs_in & ~vs_d_q;
    assign de_fall       = de_d_q & ~de_in;
    assign last_line_end = de_fall && (y_q == Y_LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            vs_d_q    <= 1'b0;
            de_d_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            vs_d_q  <= vs_in;
            de_d_q  <= de_in;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            // Address trails the strobe by one cycle so wr_addr names the pixel on wr_data.
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + AW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (key_flag) begin
                        state_q   <= S_ARM;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        x_q       <= '0;
                        y_q       <= '0;
                        wr_addr_q <= '0;
                    end
                end
                S_ARM: begin
                    if (vs_rise) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (de_in) begin
                        if (x_q < H_LIM) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= pix_in;
                        end
                        if (x_q != X_MAX) begin
                            x_q <= x_q + CW'(1);
                        end
                    end
                    if (de_fall) begin
                        if (x_q != H_LIM) begin
                            err_q <= 1'b1;
                        end
                        x_q <= '0;
                        y_q <= y_q + CW'(1);
                    end
                    // Line accounting wins over a coincident vsync; only a truncated frame is an error.
                    if (vs_rise && !last_line_end) begin
                        err_q <= 1'b1;
                    end
                    if (last_line_end || vs_rise) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

`default_nettype wire
